// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding and RAM command-frame opcodes.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RD_WAIT = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [9:0] make_frame(input logic [1:0] op, input logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set request scanning upward from ptr_i+1.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               gnt_valid_o,
  output logic [IDW-1:0]     gnt_id_o
);

  logic [IDW-1:0] idx_s;

  // Scan all requesters once, starting just after the last served one
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx_s       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = IDW'((int'(ptr_i) + i) % NUM_REQ);
      if (!gnt_valid_o && req_i[idx_s]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = idx_s;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM; turns one granted word read/write
// at a time into the RAM's 10-bit command-frame sequence and collects the read result.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [NUM_REQ*8-1:0] addr,
  input  logic [NUM_REQ*8-1:0] wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic                 ram_tx_valid,
  input  logic [7:0]           ram_dout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           gnt_valid_s;
  logic [IDW-1:0] gnt_id_s;
  logic [7:0]     sel_addr_s;
  logic [7:0]     sel_wdata_s;
  logic           sel_we_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Pull the winner's fields out of the packed request buses
  always_comb begin
    sel_addr_s  = 8'h00;
    sel_wdata_s = 8'h00;
    sel_we_s    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_id_s) begin
        sel_addr_s  = addr[8*i +: 8];
        sel_wdata_s = wdata[8*i +: 8];
        sel_we_s    = we[i];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  // State and latched-transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and latch updates; requester inputs only matter in IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          id_d    = gnt_id_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          state_d = sel_we_s ? WR_ADDR : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: state_d = DONE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ptr_d   = id_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state and latched fields
  always_comb begin
    ack          = '0;
    err          = 1'b0;
    rdata        = 8'h00;
    busy         = (state_q != IDLE);
    ram_din      = 10'h000;
    ram_rx_valid = 1'b0;
    case (state_q)
      WR_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = make_frame(CMD_WR_ADDR, addr_q);
      end
      WR_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = make_frame(CMD_WR_DATA, wdata_q);
      end
      RD_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = make_frame(CMD_RD_ADDR, addr_q);
      end
      RD_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = make_frame(CMD_RD_DATA, 8'h00);
      end
      DONE: begin
        ack[id_q] = 1'b1;
        rdata     = rdata_q;
        err       = err_q;
      end
      default: ram_rx_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a small RAM model answers frames, a scoreboard
// holds expected acks, a monitor checks every ack and collects emitted frames.
module tb_ram_arbiter;

  localparam int N  = 2;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] we = '0;
  logic [N*8-1:0] addr = '0;
  logic [N*8-1:0] wdata = '0;
  logic [N-1:0] ack;
  logic         err;
  logic [7:0]   rdata;
  logic         busy;
  logic [9:0]   ram_din;
  logic         ram_rx_valid;
  logic         ram_tx_valid;
  logic [7:0]   ram_dout;

  logic         rv = 1'b0;
  logic [7:0]   rd = 8'h00;
  logic [7:0]   ram_a = 8'h00;
  logic [7:0]   mem [256];
  logic         stray = 1'b0;
  logic         ram_mute = 1'b0;

  typedef struct {
    int         id;
    bit         rd;
    logic [7:0] rdata;
    logic       err;
    int         exp_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] fq[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int ack_count = 0;

  ram_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .err          (err),
    .rdata        (rdata),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_tx_valid (ram_tx_valid),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ram_tx_valid = rv | stray;
  assign ram_dout     = stray ? 8'hEE : rd;

  // RAM model: read data comes back one cycle after the read-data frame
  always @(posedge clk) begin
    if (ram_rx_valid && (ram_din[9:8] == 2'b00 || ram_din[9:8] == 2'b10)) ram_a <= ram_din[7:0];
    if (ram_rx_valid && ram_din[9:8] == 2'b01) mem[ram_a] <= ram_din[7:0];
    rv <= ram_rx_valid && (ram_din[9:8] == 2'b11) && !ram_mute;
    rd <= mem[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: frame capture, idle-frame zero check, ack scoreboard compare
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (ram_rx_valid) fq.push_back(ram_din);
      else chk("din_zero_when_invalid", 32'(ram_din), 32'h0);
      if (|ack) begin
        ack_count++;
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1 << e.id));
          chk("err", 32'(err), 32'(e.err));
          if (e.rd) chk("rdata", 32'(rdata), 32'(e.rdata));
          if (e.exp_cyc >= 0) chk("ack_latency", 32'(cyc), 32'(e.exp_cyc));
        end
      end else begin
        chk("err_without_ack", 32'(err), 32'h0);
      end
    end
  end

  task automatic wait_ack(input int target);
    int k = 0;
    while (ack_count < target && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("ack_wait", 32'(ack_count >= target), 32'h1);
  endtask

  task automatic pop_frame(input string tag, input logic [9:0] exp);
    int n = fq.size();
    chk({tag, "_present"}, 32'(n != 0), 32'h1);
    if (n != 0) chk(tag, 32'(fq.pop_front()), 32'(exp));
  endtask

  task automatic run_txn(input int id, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_err, input int lat,
                         input bit disturb);
    exp_t e;
    int   target;
    @(posedge clk);
    #1;
    req[id] = 1'b1;
    we[id] = w;
    addr[8*id +: 8] = a;
    wdata[8*id +: 8] = d;
    e.id = id; e.rd = !w; e.rdata = exp_rd; e.err = exp_err; e.exp_cyc = cyc + lat;
    sb.push_back(e);
    target = ack_count + 1;
    if (disturb) begin
      @(posedge clk);
      #1;
      chk("busy_mid_txn", 32'(busy), 32'h1);
      req[id] = 1'b0;
      we[id] = ~w;
      addr[8*id +: 8] = ~a;
      stray = 1'b1;
    end
    wait_ack(target);
    req[id] = 1'b0;
    stray = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   acks_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_din", 32'(ram_din), 32'h0);
    chk("rst_rxv", 32'(ram_rx_valid), 32'h0);
    rst_n = 1'b1;

    run_txn(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 3, 1'b0);
    pop_frame("wr_addr_frame", 10'h03C);
    pop_frame("wr_data_frame", 10'h1A5);

    run_txn(1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4, 1'b0);
    pop_frame("rd_addr_frame", 10'h23C);
    pop_frame("rd_data_frame", 10'h300);

    // Both requesters hold req through four grants
    @(posedge clk);
    #1;
    req = 2'b11; we = 2'b11;
    addr = {8'h20, 8'h10}; wdata = {8'h21, 8'h11};
    for (int k = 0; k < 4; k++) begin
      e.id = k % 2; e.rd = 1'b0; e.rdata = 8'h00; e.err = 1'b0; e.exp_cyc = -1;
      sb.push_back(e);
    end
    wait_ack(ack_count + 4);
    req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      pop_frame("rr0_addr", 10'h010);
      pop_frame("rr0_data", 10'h111);
      pop_frame("rr1_addr", 10'h020);
      pop_frame("rr1_data", 10'h121);
    end

    ram_mute = 1'b1;
    run_txn(0, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1, 3 + TO + 1, 1'b0);
    ram_mute = 1'b0;
    pop_frame("to_addr_frame", 10'h255);
    pop_frame("to_data_frame", 10'h300);

    run_txn(1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4, 1'b0);
    pop_frame("post_to_addr", 10'h23C);
    pop_frame("post_to_data", 10'h300);

    run_txn(0, 1'b1, 8'h77, 8'h5A, 8'h00, 1'b0, 3, 1'b1);
    pop_frame("dist_addr_frame", 10'h077);
    pop_frame("dist_data_frame", 10'h15A);
    run_txn(1, 1'b0, 8'h77, 8'h00, 8'h5A, 1'b0, 4, 1'b0);
    pop_frame("rb_addr_frame", 10'h277);
    pop_frame("rb_data_frame", 10'h300);

    // Reset asserted while the read is waiting on the RAM
    ram_mute = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_rxv", 32'(ram_rx_valid), 32'h0);
    acks_before = ack_count;
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_rdata", 32'(rdata), 32'h0);
    chk("arst_din", 32'(ram_din), 32'h0);
    chk("arst_rxv", 32'(ram_rx_valid), 32'h0);
    pop_frame("abandon_addr", 10'h23C);
    pop_frame("abandon_data", 10'h300);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ram_mute = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_no_ack", 32'(ack_count), 32'(acks_before));
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("no_extra_frames", 32'(fq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
